mem_store_unit: RTL and testbench

MEM_STORE_UNIT -- requirements
Module: mem_store_unit

---
 rtl/mem_store_unit.sv | 155 +++++++++++++++
 tb/tb_mem_store_unit.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_store_unit.sv
// mem_store_unit: accepts one store at a time and drives a single memory write.
// The unit packs the data and byte enables by access size and holds the write
// request until the memory acknowledges it or the wait limit expires. It then
// reports completion, misalignment, illegal size or timeout with a one-cycle pulse.
module mem_store_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inp_Store_Valid,
  output logic        inp_Store_Ready,
  input  logic [1:0]  inp_Store_Size,
  input  logic [31:0] inp_Store_Addr,
  input  logic [31:0] inp_Store_Data,
  output logic        mem_Req,
  output logic [31:0] mem_Addr,
  output logic [31:0] mem_Wdata,
  output logic [3:0]  mem_Byte_En,
  input  logic        mem_Ack,
  output logic        store_Done,
  output logic        store_Error,
  output logic [1:0]  error_Code
);

  // The wait counter only needs to hold 0 .. TIMEOUT-1. The last value ends the wait.
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  localparam logic [1:0] CODE_NONE     = 2'b00;
  localparam logic [1:0] CODE_MISALIGN = 2'b01;
  localparam logic [1:0] CODE_ILLEGAL  = 2'b10;
  localparam logic [1:0] CODE_TIMEOUT  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_req;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [3:0]    r_be;
  logic          r_done;
  logic          r_err;
  logic [1:0]    r_code;

  logic [31:0]   w_wdata;
  logic [3:0]    w_be;
  logic [1:0]    w_code;

  // Lane packing and request classification for the incoming store.
  always_comb begin
    w_wdata = 32'h0000_0000;
    w_be    = 4'b0000;
    w_code  = CODE_NONE;
    case (inp_Store_Size)
      2'b00: begin
        w_wdata = {4{inp_Store_Data[7:0]}};
        w_be    = 4'b0001 << inp_Store_Addr[1:0];
      end
      2'b01: begin
        w_wdata = {2{inp_Store_Data[15:0]}};
        w_be    = inp_Store_Addr[1] ? 4'b1100 : 4'b0011;
        w_code  = inp_Store_Addr[0] ? CODE_MISALIGN : CODE_NONE;
      end
      2'b10: begin
        w_wdata = inp_Store_Data;
        w_be    = 4'b1111;
        w_code  = (inp_Store_Addr[1:0] != 2'b00) ? CODE_MISALIGN : CODE_NONE;
      end
      default: begin
        // Illegal size wins over any alignment problem.
        w_code  = CODE_ILLEGAL;
      end
    endcase
  end

  // Store sequencing FSM with registered memory-side and response outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_req   <= 1'b0;
      r_addr  <= 32'h0000_0000;
      r_wdata <= 32'h0000_0000;
      r_be    <= 4'b0000;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_code  <= CODE_NONE;
    end else begin
      // Response signals are single-cycle pulses unless re-armed below.
      r_done <= 1'b0;
      r_err  <= 1'b0;
      r_code <= CODE_NONE;
      case (r_state)
        S_IDLE: begin
          if (inp_Store_Valid) begin
            if (w_code != CODE_NONE) begin
              r_state <= S_RESP;
              r_err   <= 1'b1;
              r_code  <= w_code;
            end else begin
              r_state <= S_BUSY;
              r_cnt   <= '0;
              r_req   <= 1'b1;
              r_addr  <= {inp_Store_Addr[31:2], 2'b00};
              r_wdata <= w_wdata;
              r_be    <= w_be;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_BUSY: begin
          if (mem_Ack || (r_cnt == CNT_LAST)) begin
            // An ack in the final wait cycle still counts as success.
            r_state <= S_RESP;
            r_req   <= 1'b0;
            r_addr  <= 32'h0000_0000;
            r_wdata <= 32'h0000_0000;
            r_be    <= 4'b0000;
            r_done  <= mem_Ack;
            r_err   <= ~mem_Ack;
            r_code  <= mem_Ack ? CODE_NONE : CODE_TIMEOUT;
          end else begin
            r_cnt   <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
          r_addr  <= 32'h0000_0000;
          r_wdata <= 32'h0000_0000;
          r_be    <= 4'b0000;
        end
      endcase
    end
  end

  assign inp_Store_Ready = (r_state == S_IDLE) && !reset;
  assign mem_Req         = r_req;
  assign mem_Addr        = r_addr;
  assign mem_Wdata       = r_wdata;
  assign mem_Byte_En     = r_be;
  assign store_Done      = r_done;
  assign store_Error     = r_err;
  assign error_Code      = r_code;

endmodule

// File: tb/tb_mem_store_unit.sv
// Directed testbench for mem_store_unit, built with TIMEOUT=4.
module tb_mem_store_unit;

  logic        clk;
  logic        reset;
  logic        inp_Store_Valid;
  logic        inp_Store_Ready;
  logic [1:0]  inp_Store_Size;
  logic [31:0] inp_Store_Addr;
  logic [31:0] inp_Store_Data;
  logic        mem_Req;
  logic [31:0] mem_Addr;
  logic [31:0] mem_Wdata;
  logic [3:0]  mem_Byte_En;
  logic        mem_Ack;
  logic        store_Done;
  logic        store_Error;
  logic [1:0]  error_Code;

  int n_vec = 0;
  int n_err = 0;

  mem_store_unit #(.TIMEOUT(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .inp_Store_Valid (inp_Store_Valid),
    .inp_Store_Ready (inp_Store_Ready),
    .inp_Store_Size  (inp_Store_Size),
    .inp_Store_Addr  (inp_Store_Addr),
    .inp_Store_Data  (inp_Store_Data),
    .mem_Req         (mem_Req),
    .mem_Addr        (mem_Addr),
    .mem_Wdata       (mem_Wdata),
    .mem_Byte_En     (mem_Byte_En),
    .mem_Ack         (mem_Ack),
    .store_Done      (store_Done),
    .store_Error     (store_Error),
    .error_Code      (error_Code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_checks(input string tag);
    chk({tag, "_ready"}, {31'd0, inp_Store_Ready}, 32'd1);
    chk({tag, "_done"},  {31'd0, store_Done},      32'd0);
    chk({tag, "_err"},   {31'd0, store_Error},     32'd0);
    chk({tag, "_code"},  {30'd0, error_Code},      32'd0);
  endtask

  initial begin
    reset           = 1'b1;
    inp_Store_Valid = 1'b0;
    inp_Store_Size  = 2'b00;
    inp_Store_Addr  = 32'h0;
    inp_Store_Data  = 32'h0;
    mem_Ack         = 1'b0;

    // Reset state
    step();
    chk("rst_ready", {31'd0, inp_Store_Ready}, 32'd0);
    chk("rst_req",   {31'd0, mem_Req},         32'd0);
    chk("rst_be",    {28'd0, mem_Byte_En},     32'd0);
    reset = 1'b0;
    step();
    idle_checks("post_rst");

    // Byte store at 0x1003, ack two cycles after the request first rises
    inp_Store_Valid = 1'b1; inp_Store_Size = 2'b00;
    inp_Store_Addr = 32'h0000_1003; inp_Store_Data = 32'h0000_00A5;
    step();
    inp_Store_Valid = 1'b0;
    chk("b_req",   {31'd0, mem_Req},     32'd1);
    chk("b_addr",  mem_Addr,             32'h0000_1000);
    chk("b_wdata", mem_Wdata,            32'hA5A5_A5A5);
    chk("b_be",    {28'd0, mem_Byte_En}, 32'h8);
    chk("b_ready", {31'd0, inp_Store_Ready}, 32'd0);
    step();
    chk("b_req2",  {31'd0, mem_Req},     32'd1);
    chk("b_done2", {31'd0, store_Done},  32'd0);
    step();
    mem_Ack = 1'b1;
    chk("b_req3",  {31'd0, mem_Req},     32'd1);
    step();
    mem_Ack = 1'b0;
    chk("b_done",  {31'd0, store_Done},  32'd1);
    chk("b_err",   {31'd0, store_Error}, 32'd0);
    chk("b_reqoff",{31'd0, mem_Req},     32'd0);
    chk("b_wd0",   mem_Wdata,            32'h0);
    chk("b_addr0", mem_Addr,             32'h0);
    chk("b_be0",   {28'd0, mem_Byte_En}, 32'h0);
    chk("b_rready",{31'd0, inp_Store_Ready}, 32'd0);
    step();
    idle_checks("b_end");

    // Halfword at 0x2002 with ack held high (also during idle, where it is ignored)
    inp_Store_Valid = 1'b1; inp_Store_Size = 2'b01;
    inp_Store_Addr = 32'h0000_2002; inp_Store_Data = 32'h1234_BEEF;
    mem_Ack = 1'b1;
    step();
    inp_Store_Valid = 1'b0;
    chk("h_req",   {31'd0, mem_Req},     32'd1);
    chk("h_addr",  mem_Addr,             32'h0000_2000);
    chk("h_wdata", mem_Wdata,            32'hBEEF_BEEF);
    chk("h_be",    {28'd0, mem_Byte_En}, 32'hC);
    step();
    mem_Ack = 1'b0;
    chk("h_done",  {31'd0, store_Done},  32'd1);
    chk("h_err",   {31'd0, store_Error}, 32'd0);
    step();
    idle_checks("h_end");

    // Misaligned word at 0x3001
    inp_Store_Valid = 1'b1; inp_Store_Size = 2'b10;
    inp_Store_Addr = 32'h0000_3001; inp_Store_Data = 32'h1111_2222;
    step();
    inp_Store_Valid = 1'b0;
    chk("mw_req",  {31'd0, mem_Req},     32'd0);
    chk("mw_err",  {31'd0, store_Error}, 32'd1);
    chk("mw_code", {30'd0, error_Code},  32'd1);
    chk("mw_done", {31'd0, store_Done},  32'd0);
    chk("mw_rdy",  {31'd0, inp_Store_Ready}, 32'd0);
    step();
    idle_checks("mw_end");

    // Illegal size at the same misaligned address: illegal size wins
    inp_Store_Valid = 1'b1; inp_Store_Size = 2'b11;
    inp_Store_Addr = 32'h0000_3001;
    step();
    inp_Store_Valid = 1'b0;
    chk("il_req",  {31'd0, mem_Req},     32'd0);
    chk("il_err",  {31'd0, store_Error}, 32'd1);
    chk("il_code", {30'd0, error_Code},  32'd2);
    step();
    idle_checks("il_end");

    // Misaligned halfword at 0x2001
    inp_Store_Valid = 1'b1; inp_Store_Size = 2'b01;
    inp_Store_Addr = 32'h0000_2001;
    step();
    inp_Store_Valid = 1'b0;
    chk("mh_req",  {31'd0, mem_Req},     32'd0);
    chk("mh_code", {30'd0, error_Code},  32'd1);
    step();

    // Word at 0x4000, no ack: request held exactly 4 cycles, then timeout
    inp_Store_Valid = 1'b1; inp_Store_Size = 2'b10;
    inp_Store_Addr = 32'h0000_4000; inp_Store_Data = 32'hDEAD_BEEF;
    step();
    inp_Store_Valid = 1'b0;
    chk("to_wdata", mem_Wdata,            32'hDEAD_BEEF);
    chk("to_be",    {28'd0, mem_Byte_En}, 32'hF);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("to_req%0d", i), {31'd0, mem_Req},     32'd1);
      chk($sformatf("to_err%0d", i), {31'd0, store_Error}, 32'd0);
      step();
    end
    chk("to_reqoff", {31'd0, mem_Req},     32'd0);
    chk("to_err",    {31'd0, store_Error}, 32'd1);
    chk("to_code",   {30'd0, error_Code},  32'd3);
    chk("to_done",   {31'd0, store_Done},  32'd0);
    step();
    idle_checks("to_end");

    // Same store, ack on the fourth request cycle: success wins over timeout
    inp_Store_Valid = 1'b1;
    step();
    inp_Store_Valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("ta_req%0d", i), {31'd0, mem_Req}, 32'd1);
      step();
    end
    mem_Ack = 1'b1;
    chk("ta_req3", {31'd0, mem_Req}, 32'd1);
    step();
    mem_Ack = 1'b0;
    chk("ta_done", {31'd0, store_Done},  32'd1);
    chk("ta_err",  {31'd0, store_Error}, 32'd0);
    chk("ta_code", {30'd0, error_Code},  32'd0);
    step();
    idle_checks("ta_end");

    // Reset pulsed while busy
    inp_Store_Valid = 1'b1; inp_Store_Size = 2'b10;
    inp_Store_Addr = 32'h0000_5000; inp_Store_Data = 32'hCAFE_F00D;
    step();
    inp_Store_Valid = 1'b0;
    chk("rb_req", {31'd0, mem_Req}, 32'd1);
    reset = 1'b1;
    mem_Ack = 1'b1;
    #1;
    chk("rb_req0",   {31'd0, mem_Req},         32'd0);
    chk("rb_addr0",  mem_Addr,                 32'h0);
    chk("rb_wd0",    mem_Wdata,                32'h0);
    chk("rb_rdy0",   {31'd0, inp_Store_Ready}, 32'd0);
    step();
    chk("rb_done",   {31'd0, store_Done},      32'd0);
    chk("rb_err",    {31'd0, store_Error},     32'd0);
    reset = 1'b0;
    step();
    mem_Ack = 1'b0;
    idle_checks("rb_after");
    chk("rb_req_after", {31'd0, mem_Req}, 32'd0);

    // New byte store at 0x6001 after reset, immediate ack
    inp_Store_Valid = 1'b1; inp_Store_Size = 2'b00;
    inp_Store_Addr = 32'h0000_6001; inp_Store_Data = 32'hFFFF_FF5A;
    step();
    inp_Store_Valid = 1'b0;
    mem_Ack = 1'b1;
    chk("nb_addr",  mem_Addr,             32'h0000_6000);
    chk("nb_wdata", mem_Wdata,            32'h5A5A_5A5A);
    chk("nb_be",    {28'd0, mem_Byte_En}, 32'h2);
    step();
    mem_Ack = 1'b0;
    chk("nb_done",  {31'd0, store_Done},  32'd1);
    step();
    idle_checks("nb_end");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
